// File: rtl/grid_io_pkg.sv
// Shared types and constants for the parametrised I/O grid tile.
package grid_io_pkg;

  localparam int CFG_BITS    = 3;
  localparam int CFG_DIR     = 0;
  localparam int CFG_IN_REG  = 1;
  localparam int CFG_OUT_REG = 2;

  typedef struct packed {
    logic out_reg;
    logic in_reg;
    logic dir;
  } pad_cfg_t;

endpackage

// File: rtl/grid_io_pad_cell.sv
// One pad channel: direction and optional input/output registering.
// GRID_IO_INPUT_SYNC_EN turns the input register into a 2-flop synchroniser.
module grid_io_pad_cell
  import grid_io_pkg::*;
(
  input  logic     prog_clk,
  input  logic     pReset,
  input  pad_cfg_t cfg,
  input  logic     io_outpad,
  input  logic     gpio_y,
  output logic     gpio_a,
  output logic     gpio_oe,
  output logic     io_inpad
);

  logic oreg_r;
  logic ireg_r;
`ifdef GRID_IO_INPUT_SYNC_EN
  logic sync_r;
`endif

  // Data registers sample every cycle so a mode switch never sees stale history.
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      oreg_r <= 1'b0;
      ireg_r <= 1'b0;
`ifdef GRID_IO_INPUT_SYNC_EN
      sync_r <= 1'b0;
`endif
    end else begin
      oreg_r <= io_outpad;
`ifdef GRID_IO_INPUT_SYNC_EN
      sync_r <= gpio_y;
      ireg_r <= sync_r;
`else
      ireg_r <= gpio_y;
`endif
    end
  end

  // Pad muxing from the active configuration.
  always_comb begin
    gpio_oe  = cfg.dir;
    gpio_a   = io_outpad;
    io_inpad = 1'b0;
    if (cfg.out_reg) begin
      gpio_a = oreg_r;
    end else begin
      gpio_a = io_outpad;
    end
    if (cfg.dir) begin
      io_inpad = 1'b0;
    end else if (cfg.in_reg) begin
      io_inpad = ireg_r;
    end else begin
      io_inpad = gpio_y;
    end
  end

endmodule

// File: rtl/grid_io_param_tile.sv
// Perimeter I/O tile: scan-loaded config with shadowed, all-or-nothing commit.
// Optional macro GRID_IO_INPUT_SYNC_EN (see grid_io_pad_cell).
module grid_io_param_tile
  import grid_io_pkg::*;
#(
  parameter int NUM_PADS = 5
) (
  input  logic                prog_clk,
  input  logic                pReset,
  input  logic                ccff_en,
  input  logic                ccff_head,
  output logic                ccff_tail,
  output logic                cfg_done,
  output logic                cfg_err,
  input  logic [NUM_PADS-1:0] io_outpad,
  output logic [NUM_PADS-1:0] io_inpad,
  input  logic [NUM_PADS-1:0] gfpga_pad_GPIO_Y,
  output logic [NUM_PADS-1:0] gfpga_pad_GPIO_A,
  output logic [NUM_PADS-1:0] gfpga_pad_GPIO_OE
);

  localparam int CHAIN_LEN = NUM_PADS * CFG_BITS;
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1);

  logic [CHAIN_LEN-1:0] sr_r;
  logic [CHAIN_LEN-1:0] cfg_act_r;
  logic [CNT_W-1:0]     cnt_r;
  logic                 en_prev_r;
  logic                 cfg_done_r;
  logic                 cfg_err_r;
  logic                 commit_s;
  logic                 cnt_full_s;

  assign commit_s   = en_prev_r & ~ccff_en;
  assign cnt_full_s = (cnt_r == CNT_W'(CHAIN_LEN));

  // Scan shift register and saturating bit counter.
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      sr_r      <= {CHAIN_LEN{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      en_prev_r <= 1'b0;
    end else begin
      en_prev_r <= ccff_en;
      if (ccff_en) begin
        sr_r <= {sr_r[CHAIN_LEN-2:0], ccff_head};
        if (!cnt_full_s) begin
          cnt_r <= cnt_r + CNT_W'(1);
        end
      end else if (commit_s) begin
        cnt_r <= {CNT_W{1'b0}};
      end
    end
  end

  // Commit only a complete image; a short load flags an error and leaves pads alone.
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      cfg_act_r  <= {CHAIN_LEN{1'b0}};
      cfg_done_r <= 1'b0;
      cfg_err_r  <= 1'b0;
    end else if (ccff_en) begin
      cfg_done_r <= 1'b0;
    end else if (commit_s) begin
      if (cnt_full_s) begin
        cfg_act_r  <= sr_r;
        cfg_done_r <= 1'b1;
        cfg_err_r  <= 1'b0;
      end else begin
        cfg_err_r  <= 1'b1;
      end
    end
  end

  assign ccff_tail = sr_r[CHAIN_LEN-1];
  assign cfg_done  = cfg_done_r;
  assign cfg_err   = cfg_err_r;

  // Pad 0 is shifted first, so it ends up in the top bits of the image.
  for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad
    pad_cfg_t cfg_s;
    assign cfg_s.dir     = cfg_act_r[CHAIN_LEN-1-(i*CFG_BITS+CFG_DIR)];
    assign cfg_s.in_reg  = cfg_act_r[CHAIN_LEN-1-(i*CFG_BITS+CFG_IN_REG)];
    assign cfg_s.out_reg = cfg_act_r[CHAIN_LEN-1-(i*CFG_BITS+CFG_OUT_REG)];

    grid_io_pad_cell u_cell (
      .prog_clk  (prog_clk),
      .pReset    (pReset),
      .cfg       (cfg_s),
      .io_outpad (io_outpad[i]),
      .gpio_y    (gfpga_pad_GPIO_Y[i]),
      .gpio_a    (gfpga_pad_GPIO_A[i]),
      .gpio_oe   (gfpga_pad_GPIO_OE[i]),
      .io_inpad  (io_inpad[i])
    );
  end

endmodule
